// File: rtl/serial_adder_if.sv
// Valid/ready interface for the bit-serial adder: an operand channel
// (a, b, c_in) from the producer and a result channel (sum, c_out) to the consumer.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output c_in,
    input  out_valid,
    output out_ready,
    input  sum,
    input  c_out
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  c_in,
    output out_valid,
    input  out_ready,
    output sum,
    output c_out
  );

endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit pair per clock,
// LSB first, with the carry held in a register between bits. A WIDTH-bit add takes
// WIDTH clocks in RUN, then the result is held in DONE until the consumer takes it.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_next;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             c_out_r;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             accept;
  logic             fa_s;
  logic             fa_co;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == IDLE) && bus.in_valid;

  // Single full-adder cell fed by the LSBs of the operand shifters and the carry register.
  always_comb begin
    fa_s  = a_sh[0] ^ b_sh[0] ^ carry;
    fa_co = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    sum_sh_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, hold in DONE until taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per RUN clock, capture result on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      c_out_r <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_sh_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          if (last_bit) begin
            sum_r   <= sum_sh_next;
            c_out_r <= fa_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs; in_ready is masked during reset so nothing is accepted while it is held.
  always_comb begin
    bus.in_ready  = (state == IDLE) && !rst;
    bus.out_valid = (state == DONE);
    bus.sum       = sum_r;
    bus.c_out     = c_out_r;
  end

endmodule
